vertex_fetch_sequencer: RTL and testbench

//  Draw-call controller in front of the single-vertex vertex_fetch unit. Accepts a draw command
//  (base address, first index, vertex count), then walks the index range one vertex at a time.
//  For each index it pulses the fetch unit's start, waits for its done pulse and captures the

---
 rtl/vfs_pkg.sv | 17 +
 rtl/vfs_out_reg.sv | 40 ++++
 rtl/vertex_fetch_sequencer.sv | 151 +++++++++++++++
 tb/tb_vertex_fetch_sequencer.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vfs_pkg.sv
// Shared types for the vertex fetch sequencer: FSM state encoding
// and the vertex payload width helper.
package vfs_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ZERO,
        ISSUE,
        WAIT,
        OUT
    } vfs_state_t;

    function automatic int vtx_width(input int attr_w, input int attrs);
        return attr_w * attrs;
    endfunction

endpackage

// File: rtl/vfs_out_reg.sv
// Output holding register: captures a fetched vertex and holds
// data, index and last stable until the downstream handshake.
module vfs_out_reg #(
    parameter int VTX_W     = 256,
    parameter int IDX_WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic                 flush,
    input  logic [VTX_W-1:0]     load_data,
    input  logic [IDX_WIDTH-1:0] load_index,
    input  logic                 load_last,
    input  logic                 ready,
    output logic                 valid,
    output logic [VTX_W-1:0]     data,
    output logic [IDX_WIDTH-1:0] index,
    output logic                 last,
    output logic                 fire
);

    assign fire = valid & ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid <= 1'b0;
            data  <= '0;
            index <= '0;
            last  <= 1'b0;
        end else if (load) begin
            valid <= 1'b1;
            data  <= load_data;
            index <= load_index;
            last  <= load_last;
        end else if (fire || flush) begin
            valid <= 1'b0;
        end
    end

endmodule

// File: rtl/vertex_fetch_sequencer.sv
// Draw-call sequencer feeding the single-vertex fetch unit.
// Optional VFS_STALL_CNT_EN adds an output back-pressure cycle counter.
module vertex_fetch_sequencer
    import vfs_pkg::*;
#(
    parameter int ATTR_WIDTH       = 32,
    parameter int ATTRS_PER_VERTEX = 8,
    parameter int ADDR_WIDTH       = 32,
    parameter int IDX_WIDTH        = 16,
    parameter int CNT_WIDTH        = 16
) (
    input  logic                                   clk,
    input  logic                                   rst_n,
    input  logic                                   i_cmd_valid,
    output logic                                   o_cmd_ready,
    input  logic [ADDR_WIDTH-1:0]                  i_cmd_base,
    input  logic [IDX_WIDTH-1:0]                   i_cmd_first,
    input  logic [CNT_WIDTH-1:0]                   i_cmd_count,
    input  logic                                   i_abort,
    output logic                                   o_fetch_start,
    output logic [ADDR_WIDTH-1:0]                  o_fetch_base,
    output logic [IDX_WIDTH-1:0]                   o_fetch_index,
    input  logic                                   i_fetch_done,
    input  logic [ATTR_WIDTH*ATTRS_PER_VERTEX-1:0] i_fetch_data,
    output logic                                   o_vtx_valid,
    input  logic                                   i_vtx_ready,
    output logic [ATTR_WIDTH*ATTRS_PER_VERTEX-1:0] o_vtx_data,
    output logic [IDX_WIDTH-1:0]                   o_vtx_index,
    output logic                                   o_vtx_last,
    output logic                                   o_busy,
    output logic                                   o_draw_done,
    output logic [31:0]                            o_stall_cycles
);

    localparam int VTX_W = vtx_width(ATTR_WIDTH, ATTRS_PER_VERTEX);

    vfs_state_t           state;
    logic [ADDR_WIDTH-1:0] base;
    logic [IDX_WIDTH-1:0]  cur_idx;
    logic [CNT_WIDTH-1:0]  remaining;
    logic                  aborted;
    logic                  start_q;
    logic                  cmd_fire;
    logic                  load;
    logic                  flush;
    logic                  fire;

    assign cmd_fire = i_cmd_valid & o_cmd_ready;
    // A fetch abandoned by abort is still consumed but never presented
    assign load  = (state == WAIT) & i_fetch_done & ~aborted & ~i_abort;
    assign flush = (state == OUT) & i_abort;

    assign o_cmd_ready   = (state == IDLE);
    assign o_busy        = (state != IDLE);
    assign o_fetch_start = start_q;
    assign o_fetch_base  = base;
    assign o_fetch_index = cur_idx;
    assign o_draw_done   = (state == ZERO) |
                           ((state == OUT) & fire & o_vtx_last & ~i_abort);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            base      <= '0;
            cur_idx   <= '0;
            remaining <= '0;
            aborted   <= 1'b0;
            start_q   <= 1'b0;
        end else begin
            start_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (cmd_fire) begin
                        base      <= i_cmd_base;
                        cur_idx   <= i_cmd_first;
                        remaining <= i_cmd_count;
                        aborted   <= 1'b0;
                        if (i_cmd_count == '0) begin
                            state <= ZERO;
                        end else begin
                            state   <= ISSUE;
                            start_q <= 1'b1;
                        end
                    end
                end
                ZERO: state <= IDLE;
                ISSUE: begin
                    state <= WAIT;
                    if (i_abort) aborted <= 1'b1;
                end
                WAIT: begin
                    if (i_abort) aborted <= 1'b1;
                    if (i_fetch_done) begin
                        state <= (aborted | i_abort) ? IDLE : OUT;
                    end
                end
                OUT: begin
                    if (fire) begin
                        remaining <= remaining - CNT_WIDTH'(1);
                        cur_idx   <= cur_idx + IDX_WIDTH'(1);
                    end
                    if (i_abort || (fire && o_vtx_last)) begin
                        state <= IDLE;
                    end else if (fire) begin
                        state   <= ISSUE;
                        start_q <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    vfs_out_reg #(
        .VTX_W     (VTX_W),
        .IDX_WIDTH (IDX_WIDTH)
    ) u_out_reg (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .flush      (flush),
        .load_data  (i_fetch_data),
        .load_index (cur_idx),
        .load_last  (remaining == CNT_WIDTH'(1)),
        .ready      (i_vtx_ready),
        .valid      (o_vtx_valid),
        .data       (o_vtx_data),
        .index      (o_vtx_index),
        .last       (o_vtx_last),
        .fire       (fire)
    );

`ifdef VFS_STALL_CNT_EN
    logic [31:0] stall_cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if (cmd_fire) begin
            stall_cnt <= '0;
        end else if (o_vtx_valid && !i_vtx_ready && !(&stall_cnt)) begin
            stall_cnt <= stall_cnt + 32'd1;
        end
    end

    assign o_stall_cycles = stall_cnt;
`else
    assign o_stall_cycles = 32'd0;
`endif

endmodule

// File: tb/tb_vertex_fetch_sequencer.sv
// Bench for vertex_fetch_sequencer: draw-level model with a per-cycle
// compare process plus directed draws with literal expectations.
module tb_vertex_fetch_sequencer;

    localparam int FETCH_LAT = 3;

    typedef struct {
        logic [15:0] idx;
        logic        last;
    } vexp_t;

    logic         clk;
    logic         rst_n;
    logic         i_cmd_valid;
    logic         o_cmd_ready;
    logic [31:0]  i_cmd_base;
    logic [15:0]  i_cmd_first;
    logic [15:0]  i_cmd_count;
    logic         i_abort;
    logic         o_fetch_start;
    logic [31:0]  o_fetch_base;
    logic [15:0]  o_fetch_index;
    logic         i_fetch_done;
    logic [255:0] i_fetch_data;
    logic         o_vtx_valid;
    logic         i_vtx_ready;
    logic [255:0] o_vtx_data;
    logic [15:0]  o_vtx_index;
    logic         o_vtx_last;
    logic         o_busy;
    logic         o_draw_done;
    logic [31:0]  o_stall_cycles;

    int checks = 0;
    int errors = 0;

    logic [15:0]  exp_fetch[$];
    vexp_t        exp_vtx[$];
    logic [15:0]  hs_idx_log[$];
    logic         hs_last_log[$];
    logic [31:0]  cur_base;
    logic [255:0] last_hs_data;
    int           n_start = 0;
    int           n_hs = 0;
    int           n_done = 0;
    int           hs_in_draw = 0;
    int           stall_vtx = 0;
    int           stall_len = 0;
    int           stray_req = 0;
    int           s0, h0, d0;

    vertex_fetch_sequencer dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_cmd_valid    (i_cmd_valid),
        .o_cmd_ready    (o_cmd_ready),
        .i_cmd_base     (i_cmd_base),
        .i_cmd_first    (i_cmd_first),
        .i_cmd_count    (i_cmd_count),
        .i_abort        (i_abort),
        .o_fetch_start  (o_fetch_start),
        .o_fetch_base   (o_fetch_base),
        .o_fetch_index  (o_fetch_index),
        .i_fetch_done   (i_fetch_done),
        .i_fetch_data   (i_fetch_data),
        .o_vtx_valid    (o_vtx_valid),
        .i_vtx_ready    (i_vtx_ready),
        .o_vtx_data     (o_vtx_data),
        .o_vtx_index    (o_vtx_index),
        .o_vtx_last     (o_vtx_last),
        .o_busy         (o_busy),
        .o_draw_done    (o_draw_done),
        .o_stall_cycles (o_stall_cycles)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [255:0] vdata(input logic [15:0] idx);
        logic [255:0] d;
        for (int k = 0; k < 8; k++) d[k*32 +: 32] = {idx, 8'(k), 8'h5A};
        return d;
    endfunction

    task automatic chk(input string name, input logic [255:0] act,
                       input logic [255:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        errors++;
        $display("FAIL %s actual=timeout required=event", name);
    endtask

    // Fetch unit stand-in: done FETCH_LAT cycles after start
    initial begin
        logic [15:0] ix;
        int stray_ack;
        stray_ack = 0;
        i_fetch_done = 1'b0;
        i_fetch_data = '0;
        forever begin
            @(negedge clk);
            if (rst_n && o_fetch_start) begin
                ix = o_fetch_index;
                repeat (FETCH_LAT) @(posedge clk);
                #1;
                i_fetch_done = 1'b1;
                i_fetch_data = vdata(ix);
                @(posedge clk);
                #1 i_fetch_done = 1'b0;
            end else if (stray_req != stray_ack) begin
                stray_ack = stray_req;
                @(posedge clk);
                #1;
                i_fetch_done = 1'b1;
                i_fetch_data = {8{32'hDEADBEEF}};
                @(posedge clk);
                #1 i_fetch_done = 1'b0;
            end
        end
    end

    // Downstream: stall vertex number stall_vtx for stall_len cycles
    initial begin
        int st_cnt;
        st_cnt = 0;
        i_vtx_ready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (o_vtx_valid && hs_in_draw == stall_vtx && st_cnt < stall_len) begin
                i_vtx_ready = 1'b0;
                st_cnt++;
            end else begin
                i_vtx_ready = 1'b1;
                if (!o_busy) st_cnt = 0;
            end
        end
    end

    // Draw-level model and per-cycle compare
    bit    p_acc, p_done, p_hs, p_valid, hs, exp_done;
    bit    zero_due;
    vexp_t ve;
    always @(negedge clk) begin
        if (!rst_n) begin
            p_acc = 0; p_done = 0; p_hs = 0; p_valid = 0; zero_due = 0;
            exp_fetch.delete();
            exp_vtx.delete();
        end else begin
            hs = o_vtx_valid && i_vtx_ready;
            exp_done = zero_due;
            zero_due = 0;
            chk("cmd_ready", o_cmd_ready, !o_busy);
            if (o_fetch_start) begin
                n_start++;
                if (exp_fetch.size() == 0) fail("fetch_unexpected");
                else begin
                    chk("fetch_one_at_a_time", exp_fetch.size(), exp_vtx.size());
                    chk("fetch_timing", p_acc | p_hs, 1);
                    chk("fetch_base", o_fetch_base, cur_base);
                    chk("fetch_index", o_fetch_index, exp_fetch.pop_front());
                end
            end
            if (o_vtx_valid) begin
                if (exp_vtx.size() == 0) fail("vtx_unexpected");
                else begin
                    chk("vtx_was_fetched", exp_vtx.size(), exp_fetch.size() + 1);
                    if (!p_valid) chk("vtx_latency", p_done, 1);
                    chk("vtx_index", o_vtx_index, exp_vtx[0].idx);
                    chk("vtx_last", o_vtx_last, exp_vtx[0].last);
                    chk("vtx_data", o_vtx_data, vdata(exp_vtx[0].idx));
                    if (hs) begin
                        if (exp_vtx[0].last) exp_done = 1;
                        hs_idx_log.push_back(o_vtx_index);
                        hs_last_log.push_back(o_vtx_last);
                        last_hs_data = o_vtx_data;
                        n_hs++;
                        hs_in_draw++;
                        void'(exp_vtx.pop_front());
                    end
                end
            end
            if (o_draw_done) n_done++;
            chk("draw_done", o_draw_done, exp_done);
            if (i_abort && o_busy) begin
                exp_fetch.delete();
                exp_vtx.delete();
            end
            p_acc = 0;
            if (i_cmd_valid && o_cmd_ready) begin
                p_acc = 1;
                cur_base = i_cmd_base;
                hs_in_draw = 0;
                hs_idx_log.delete();
                hs_last_log.delete();
                for (int k = 0; k < int'(i_cmd_count); k++) begin
                    ve.idx  = i_cmd_first + 16'(k);
                    ve.last = (k == int'(i_cmd_count) - 1);
                    exp_fetch.push_back(ve.idx);
                    exp_vtx.push_back(ve);
                end
                if (i_cmd_count == 16'd0) zero_due = 1;
            end
            p_done  = i_fetch_done;
            p_hs    = hs;
            p_valid = o_vtx_valid;
        end
    end

    task automatic send_cmd(input logic [31:0] b, input logic [15:0] f,
                            input logic [15:0] c);
        int t;
        t = 0;
        @(posedge clk);
        #1;
        i_cmd_valid = 1'b1;
        i_cmd_base  = b;
        i_cmd_first = f;
        i_cmd_count = c;
        @(negedge clk);
        while (!o_cmd_ready && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!o_cmd_ready) fail("cmd_accept_timeout");
        @(posedge clk);
        #1 i_cmd_valid = 1'b0;
    endtask

    task automatic wait_idle(input string name);
        int t;
        t = 0;
        @(negedge clk);
        while (!o_cmd_ready && t < 300) begin
            @(negedge clk);
            t++;
        end
        if (!o_cmd_ready) fail(name);
        repeat (2) @(negedge clk);
    endtask

    task automatic snap();
        s0 = n_start;
        h0 = n_hs;
        d0 = n_done;
    endtask

    task automatic deltas(input string name, input int s, input int h, input int d);
        chk({name, "_starts"}, n_start - s0, s);
        chk({name, "_vertices"}, n_hs - h0, h);
        chk({name, "_dones"}, n_done - d0, d);
    endtask

    initial begin
        int t;
        logic [31:0] w;
        rst_n = 1'b0;
        i_cmd_valid = 1'b0;
        i_cmd_base = '0;
        i_cmd_first = '0;
        i_cmd_count = '0;
        i_abort = 1'b0;
        #3;
        chk("rst_cmd_ready", o_cmd_ready, 1);
        chk("rst_busy", o_busy, 0);
        chk("rst_fetch_start", o_fetch_start, 0);
        chk("rst_fetch_base", o_fetch_base, 0);
        chk("rst_fetch_index", o_fetch_index, 0);
        chk("rst_vtx_valid", o_vtx_valid, 0);
        chk("rst_vtx_data", o_vtx_data, 0);
        chk("rst_vtx_index", o_vtx_index, 0);
        chk("rst_vtx_last", o_vtx_last, 0);
        chk("rst_draw_done", o_draw_done, 0);
        chk("rst_stall", o_stall_cycles, 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;

        // basic three-vertex draw
        snap();
        send_cmd(32'h0000_1000, 16'd5, 16'd3);
        wait_idle("t1_idle_timeout");
        deltas("t1", 3, 3, 1);
        chk("t1_log_size", hs_idx_log.size(), 3);
        if (hs_idx_log.size() == 3) begin
            chk("t1_idx0", hs_idx_log[0], 16'h0005);
            chk("t1_idx2", hs_idx_log[2], 16'h0007);
            chk("t1_last", {hs_last_log[0], hs_last_log[1], hs_last_log[2]}, 3'b001);
        end
        w = last_hs_data[31:0];
        chk("t1_data_lo", w, 32'h0007_005A);
        w = last_hs_data[255:224];
        chk("t1_data_hi", w, 32'h0007_075A);
        chk("t1_stall", o_stall_cycles, 0);

        // empty draw
        snap();
        send_cmd(32'h0000_2000, 16'd9, 16'd0);
        wait_idle("t2_idle_timeout");
        deltas("t2", 0, 0, 1);

        // back-pressure on the second vertex
        stall_vtx = 1;
        stall_len = 4;
        snap();
        send_cmd(32'h0000_3000, 16'h0020, 16'd3);
        wait_idle("t3_idle_timeout");
        deltas("t3", 3, 3, 1);
`ifdef VFS_STALL_CNT_EN
        chk("t3_stall", o_stall_cycles, 4);
`else
        chk("t3_stall", o_stall_cycles, 0);
`endif
        stall_len = 0;

        // index wrap
        snap();
        send_cmd(32'h0000_5000, 16'hFFFE, 16'd3);
        wait_idle("t4_idle_timeout");
        deltas("t4", 3, 3, 1);
        chk("t4_log_size", hs_idx_log.size(), 3);
        if (hs_idx_log.size() == 3) begin
            chk("t4_idx0", hs_idx_log[0], 16'hFFFE);
            chk("t4_idx1", hs_idx_log[1], 16'hFFFF);
            chk("t4_idx2", hs_idx_log[2], 16'h0000);
            chk("t4_last", {hs_last_log[0], hs_last_log[1], hs_last_log[2]}, 3'b001);
        end

        // abort while waiting on vertex 2 of 4
        snap();
        send_cmd(32'h0000_6000, 16'h0100, 16'd4);
        t = 0;
        while (n_start < s0 + 2 && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (n_start < s0 + 2) fail("t5_second_start_timeout");
        @(posedge clk);
        #1 i_abort = 1'b1;
        @(posedge clk);
        #1 i_abort = 1'b0;
        wait_idle("t5_idle_timeout");
        deltas("t5", 2, 1, 0);
        chk("t5_cmd_ready", o_cmd_ready, 1);
        snap();
        send_cmd(32'h0000_7000, 16'h0200, 16'd2);
        wait_idle("t5b_idle_timeout");
        deltas("t5b", 2, 2, 1);
        if (hs_idx_log.size() == 2) chk("t5b_idx1", hs_idx_log[1], 16'h0201);
        else fail("t5b_log_size");

        // asynchronous reset while presenting a vertex
        stall_vtx = 0;
        stall_len = 100;
        send_cmd(32'h0000_8000, 16'h0030, 16'd3);
        t = 0;
        @(negedge clk);
        while (!o_vtx_valid && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (!o_vtx_valid) fail("t6_valid_timeout");
        #2 rst_n = 1'b0;
        #1;
        chk("t6_vtx_valid", o_vtx_valid, 0);
        chk("t6_busy", o_busy, 0);
        chk("t6_cmd_ready", o_cmd_ready, 1);
        chk("t6_vtx_data", o_vtx_data, 0);
        chk("t6_vtx_index", o_vtx_index, 0);
        chk("t6_fetch_index", o_fetch_index, 0);
        chk("t6_draw_done", o_draw_done, 0);
        stall_len = 0;
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b1;
        snap();
        stray_req++;
        repeat (10) @(negedge clk);
        deltas("t6", 0, 0, 0);
        chk("t6_idle_after_stray", o_busy, 0);
        snap();
        send_cmd(32'h0000_9000, 16'h0042, 16'd1);
        wait_idle("t6b_idle_timeout");
        deltas("t6b", 1, 1, 1);
        if (hs_idx_log.size() == 1) chk("t6b_idx", hs_idx_log[0], 16'h0042);
        else fail("t6b_log_size");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
